// File: rtl/ntru_pkg.sv
// Shared constants and FSM state type for the NTRU polynomial arithmetic blocks.
package ntru_pkg;

  // Coefficients per polynomial and coefficient width (modulus 2^Q_BITS).
  localparam int N_COEF = 701;
  localparam int Q_BITS = 13;

  // Control FSM states of the streaming polynomial subtractor.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Ceiling log2 with a floor of one bit, for counter sizing.
  function automatic int cnt_bits(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sub_2i13_o13.sv
// Combinational W-bit modular subtractor built as a + ~b + 1.
// The half-sum slice produces generate/propagate; the prefix section
// resolves carries with a Kogge-Stone tree whose bit-0 carry-in is
// folded into the first generate, so the final borrow simply falls off.
module sub_2i13_o13
  import ntru_pkg::*;
#(
  parameter int W = Q_BITS
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hs_g,
  output logic [W-1:0] hs_p,
  input  logic [W-1:0] g_in,
  input  logic [W-1:0] p_in,
  output logic [W-1:0] diff
);

  localparam int LV = cnt_bits(W);

  logic [W-1:0] gl [0:LV];
  logic [W-1:0] pl [0:LV];
  logic [W-1:0] carry;

  // Half-sum slice: generate and propagate of a + ~b.
  always_comb begin
    hs_g = a & ~b;
    hs_p = a ^ ~b;
  end

  // Prefix tree: black cells (G,P) while the span is partial, grey cells (G only) once it reaches bit 0.
  always_comb begin
    for (int l = 0; l <= LV; l++) begin
      gl[l] = '0;
      pl[l] = '0;
    end
    gl[0]    = g_in;
    pl[0]    = p_in;
    gl[0][0] = g_in[0] | p_in[0];
    for (int l = 1; l <= LV; l++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << (l - 1))) begin
          gl[l][i] = gl[l-1][i] | (pl[l-1][i] & gl[l-1][i - (1 << (l - 1))]);
          if (i >= (2 << (l - 1))) begin
            pl[l][i] = pl[l-1][i] & pl[l-1][i - (1 << (l - 1))];
          end else begin
            pl[l][i] = pl[l-1][i];
          end
        end else begin
          gl[l][i] = gl[l-1][i];
          pl[l][i] = pl[l-1][i];
        end
      end
    end
  end

  // Sum: carry into bit 0 is the +1 of two's complement negation; carry out of the MSB is dropped.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < W; i++) begin
      carry[i] = gl[LV][i-1];
    end
    diff = p_in ^ carry;
  end

endmodule

// File: rtl/poly_sub_q13.sv
// Streaming polynomial subtractor: out[i] = (a[i] - b[i]) mod 2^W for N
// coefficients per start pulse, through a two-stage valid/ready pipeline.
// Stage 1 holds the half-sum generate/propagate, stage 2 the resolved result.
module poly_sub_q13
  import ntru_pkg::*;
#(
  parameter int N = N_COEF,
  parameter int W = Q_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_coef,
  input  logic [W-1:0] b_coef,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_coef,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam int              CW       = cnt_bits(N);
  localparam logic [CW-1:0]   LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;

  logic          s1_valid;
  logic [W-1:0]  s1_g;
  logic [W-1:0]  s1_p;

  logic [W-1:0]  hs_g;
  logic [W-1:0]  hs_p;
  logic [W-1:0]  diff;

  logic          adv1;
  logic          adv2;
  logic          in_fire;
  logic          out_fire;

  sub_2i13_o13 #(
    .W (W)
  ) u_sub (
    .a    (a_coef),
    .b    (b_coef),
    .hs_g (hs_g),
    .hs_p (hs_p),
    .g_in (s1_g),
    .p_in (s1_p),
    .diff (diff)
  );

  // Handshake: a stage advances when empty or when the stage below it advances.
  always_comb begin
    adv2     = 1'b0;
    adv1     = 1'b0;
    in_ready = 1'b0;
    in_fire  = 1'b0;
    out_fire = 1'b0;
    adv2     = ~out_valid | out_ready;
    adv1     = ~s1_valid | adv2;
    if (state == ST_RUN) begin
      in_ready = adv1;
    end else begin
      in_ready = 1'b0;
    end
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
  end

  // Last flag follows the output counter so it stays aligned through stalls and bubbles.
  always_comb begin
    out_last = 1'b0;
    if (out_valid && (out_cnt == LAST_IDX)) begin
      out_last = 1'b1;
    end else begin
      out_last = 1'b0;
    end
  end

  // Control FSM: counters, busy and the one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            in_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (in_fire) begin
            in_cnt <= in_cnt + CNT_ONE;
            if (in_cnt == LAST_IDX) begin
              state <= ST_DRAIN;
            end
          end
          if (out_fire) begin
            out_cnt <= out_cnt + CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (out_cnt == LAST_IDX) begin
              state   <= ST_IDLE;
              out_cnt <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              out_cnt <= out_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath pipeline: stage 1 half-sums, stage 2 resolved difference held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_g      <= '0;
      s1_p      <= '0;
      out_valid <= 1'b0;
      out_coef  <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_g <= hs_g;
          s1_p <= hs_p;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_coef <= diff;
        end
      end
    end
  end

endmodule
